// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: EX_MEM / MEM_WB bundle layout, MEM stage
// state encoding and the MEM_WB packing helper.
package mips_pkg;

   localparam int EX_MEM_W = 73;
   localparam int MEM_WB_W = 71;

   localparam int EXM_DEST_LSB  = 0;
   localparam int EXM_ALU_LSB   = 5;
   localparam int EXM_WDATA_LSB = 37;
   localparam int EXM_MEMWRITE  = 69;
   localparam int EXM_MEMREAD   = 70;
   localparam int EXM_MEMTOREG  = 71;
   localparam int EXM_REGWRITE  = 72;

   localparam int MWB_DEST_LSB  = 0;
   localparam int MWB_ALU_LSB   = 5;
   localparam int MWB_DATA_LSB  = 37;
   localparam int MWB_MEMTOREG  = 69;
   localparam int MWB_REGWRITE  = 70;

   localparam logic [MEM_WB_W-1:0] BUBBLE = '0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   function automatic logic [MEM_WB_W-1:0] pack_mem_wb(
      input logic        reg_write,
      input logic        memto_reg,
      input logic [31:0] mem_data,
      input logic [31:0] alu_result,
      input logic [4:0]  dest
   );
      return {reg_write, memto_reg, mem_data, alu_result, dest};
   endfunction

endpackage

// File: rtl/mem_ctrl_fsm.sv
// Memory access controller for the MEM stage: tracks the outstanding request,
// counts WAIT cycles and decides stall, completion and timeout.
module mem_ctrl_fsm
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic dmem_ack,
   output logic idle,
   output logic req,
   output logic stall,
   output logic launch,
   output logic complete,
   output logic timeout_hit
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   mem_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic at_last;

   assign at_last = (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            cnt <= '0;
         else if (!dmem_ack)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = WAIT;
         WAIT: if (dmem_ack || at_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // An ack in the final counted cycle still completes; only a missing ack times out.
   always_comb begin
      idle        = (state == IDLE);
      req         = (state == WAIT);
      launch      = idle && start;
      complete    = req && dmem_ack;
      timeout_hit = req && !dmem_ack && at_last;
      stall       = launch || (req && !dmem_ack && !at_last);
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: runs loads/stores over a req/ack
// data memory port and produces the registered MEM_WB bundle.
module mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int MEM_WB_W    = 71
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [72:0]         EX_MEM,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [31:0]         dmem_addr,
   output logic [31:0]         dmem_wdata,
   input  logic [31:0]         dmem_rdata,
   input  logic                dmem_ack,
   output logic                mem_stall,
   output logic [MEM_WB_W-1:0] MEM_WB,
   output logic                misalign_err,
   output logic                timeout_err
);

   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_write, mem_read, memto_reg, reg_write;
   logic        mem_op, misaligned, start;
   logic        idle, launch, complete, timeout_hit;

   logic        rw_q, mtr_q;
   logic [4:0]  dest_q;

   assign dest       = EX_MEM[EXM_DEST_LSB +: 5];
   assign alu_result = EX_MEM[EXM_ALU_LSB +: 32];
   assign store_data = EX_MEM[EXM_WDATA_LSB +: 32];
   assign mem_write  = EX_MEM[EXM_MEMWRITE];
   assign mem_read   = EX_MEM[EXM_MEMREAD];
   assign memto_reg  = EX_MEM[EXM_MEMTOREG];
   assign reg_write  = EX_MEM[EXM_REGWRITE];

   assign mem_op     = mem_read || mem_write;
   assign misaligned = mem_op && (alu_result[1:0] != 2'b00);
   assign start      = mem_op && !misaligned;

   mem_ctrl_fsm #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dmem_ack   (dmem_ack),
      .idle       (idle),
      .req        (dmem_req),
      .stall      (mem_stall),
      .launch     (launch),
      .complete   (complete),
      .timeout_hit(timeout_hit)
   );

   // Address, data and direction are captured once at launch so the memory
   // sees a stable request for the whole WAIT period; MemWrite wins over MemRead.
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_we      <= 1'b0;
         rw_q         <= 1'b0;
         mtr_q        <= 1'b0;
         dest_q       <= '0;
         MEM_WB       <= MEM_WB_W'(BUBBLE);
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         if (launch) begin
            dmem_addr  <= alu_result;
            dmem_wdata <= store_data;
            dmem_we    <= mem_write;
            rw_q       <= reg_write;
            mtr_q      <= memto_reg;
            dest_q     <= dest;
         end

         if (idle && !mem_op)
            MEM_WB <= MEM_WB_W'(pack_mem_wb(reg_write, memto_reg, 32'h0, alu_result, dest));
         else if (complete)
            MEM_WB <= MEM_WB_W'(pack_mem_wb(rw_q, mtr_q, dmem_we ? 32'h0 : dmem_rdata,
                                            dmem_addr, dest_q));
         else
            MEM_WB <= MEM_WB_W'(BUBBLE);

         if (idle && misaligned)
            misalign_err <= 1'b1;
         if (timeout_hit)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences for
// reset/ack corner cases, and random transactions against a transaction model.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [72:0] EX_MEM;
   logic        dmem_req, dmem_we, dmem_ack, mem_stall;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [70:0] MEM_WB;
   logic        misalign_err, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_mis = 1'b0;
   logic exp_to  = 1'b0;

   typedef struct {
      logic [72:0] ex;
      int          ack_delay;
      logic [31:0] rdata;
      logic [70:0] exp_wb;
      int          exp_stall;
      logic        exp_mis;
      logic        exp_to;
   } vec_t;

   mem_stage #(.TIMEOUT_CYC(TO), .MEM_WB_W(71)) dut (
      .clk         (clk),
      .rst         (rst),
      .EX_MEM      (EX_MEM),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ack    (dmem_ack),
      .mem_stall   (mem_stall),
      .MEM_WB      (MEM_WB),
      .misalign_err(misalign_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [72:0] mk(input logic rw, input logic mtr, input logic mr,
                                      input logic mw, input logic [31:0] wd,
                                      input logic [31:0] addr, input logic [4:0] dest);
      return {rw, mtr, mr, mw, wd, addr, dest};
   endfunction

   // Transaction-level model: outcome of one EX_MEM value given the memory's ack delay.
   function automatic vec_t model_vec(input logic [72:0] ex, input int d,
                                      input logic [31:0] rd, input logic mis_in,
                                      input logic to_in);
      vec_t v;
      logic [31:0] addr;
      addr = ex[36:5];
      v.ex = ex; v.ack_delay = d; v.rdata = rd;
      v.exp_mis = mis_in; v.exp_to = to_in;
      if (!(ex[70] || ex[69])) begin
         v.exp_wb = {ex[72], ex[71], 32'h0, addr, ex[4:0]};
         v.exp_stall = 0;
      end else if (addr[1:0] != 2'b00) begin
         v.exp_wb = '0;
         v.exp_stall = 0;
         v.exp_mis = 1'b1;
      end else if (d < TO) begin
         v.exp_wb = {ex[72], ex[71], ex[69] ? 32'h0 : rd, addr, ex[4:0]};
         v.exp_stall = d + 1;
      end else begin
         v.exp_wb = '0;
         v.exp_stall = TO;
         v.exp_to = 1'b1;
      end
      return v;
   endfunction

   // Entered and left at posedge+1; plays the memory side and checks one transaction.
   task automatic applyStimulus(input vec_t v, input string tag);
      int waits = 0, stalls = 0, reqs = 0;
      bit done = 0, bus_ok = 1, bubble_ok = 1;
      logic aligned_mem;
      aligned_mem = (v.ex[70] || v.ex[69]) && (v.ex[6:5] == 2'b00);
      EX_MEM = v.ex;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (dmem_req) begin
            dmem_ack   = (waits == v.ack_delay);
            dmem_rdata = dmem_ack ? v.rdata : $urandom;
            waits++;
         end else begin
            dmem_ack = 1'b0;
         end
         #3;
         if (c > 0 && aligned_mem && MEM_WB !== '0) bubble_ok = 0;
         if (mem_stall) stalls++;
         if (dmem_req) begin
            reqs++;
            if (dmem_addr !== v.ex[36:5] || dmem_wdata !== v.ex[68:37] ||
                dmem_we !== v.ex[69]) bus_ok = 0;
         end
         if (!mem_stall) done = 1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL %s stall_release: got stuck expected release", tag);
      end
      @(posedge clk); #1;
      EX_MEM = '0; dmem_ack = 1'b0;
      checkOutput({tag, " mem_wb"}, 128'(MEM_WB), 128'(v.exp_wb));
      checkOutput({tag, " stall_cycles"}, 128'(stalls), 128'(v.exp_stall));
      checkOutput({tag, " req_cycles"}, 128'(reqs), 128'(v.exp_stall));
      checkOutput({tag, " bus_stable"}, 128'(bus_ok), 128'(1));
      checkOutput({tag, " wait_bubbles"}, 128'(bubble_ok), 128'(1));
      checkOutput({tag, " misalign_err"}, 128'(misalign_err), 128'(v.exp_mis));
      checkOutput({tag, " timeout_err"}, 128'(timeout_err), 128'(v.exp_to));
   endtask

   vec_t table_v[8];
   vec_t rv;

   initial begin
      table_v[0] = '{mk(1,0,0,0,32'h0,32'h10,5'd3), 0, 32'h0,
                     {1'b1,1'b0,32'h0,32'h10,5'd3}, 0, 1'b0, 1'b0};
      table_v[1] = '{mk(1,1,1,0,32'h0,32'h100,5'd7), 3, 32'hDEAD_BEEF,
                     {1'b1,1'b1,32'hDEAD_BEEF,32'h100,5'd7}, 4, 1'b0, 1'b0};
      table_v[2] = '{mk(0,0,0,1,32'h1234,32'h20,5'd0), 0, 32'h5555_5555,
                     {1'b0,1'b0,32'h0,32'h20,5'd0}, 1, 1'b0, 1'b0};
      table_v[3] = '{mk(1,1,1,0,32'h0,32'h102,5'd4), 0, 32'h0,
                     71'h0, 0, 1'b1, 1'b0};
      table_v[4] = '{mk(1,1,1,0,32'h0,32'h40,5'd5), 99, 32'h0,
                     71'h0, 4, 1'b1, 1'b1};
      table_v[5] = '{mk(1,0,0,0,32'h0,32'hABCD,5'd9), 0, 32'h0,
                     {1'b1,1'b0,32'h0,32'hABCD,5'd9}, 0, 1'b1, 1'b1};
      table_v[6] = '{mk(1,1,1,0,32'h0,32'h44,5'd12), 3, 32'hCAFE_F00D,
                     {1'b1,1'b1,32'hCAFE_F00D,32'h44,5'd12}, 4, 1'b1, 1'b1};
      table_v[7] = '{mk(1,1,1,1,32'h77,32'h48,5'd2), 1, 32'h9999_0000,
                     {1'b1,1'b1,32'h0,32'h48,5'd2}, 2, 1'b1, 1'b1};

      rst = 1'b1; EX_MEM = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset mem_wb", 128'(MEM_WB), 128'(0));
      checkOutput("reset bus", 128'({dmem_req, dmem_we, dmem_addr, dmem_wdata}), 128'(0));
      checkOutput("reset flags", 128'({misalign_err, timeout_err}), 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         applyStimulus(table_v[i], $sformatf("vec%0d", i));

      // A stray ack while idle must not create a request or disturb the ALU result.
      EX_MEM = mk(1,0,0,0,32'h0,32'h3C,5'd8); dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      #3;
      checkOutput("idle_ack stall", 128'({mem_stall, dmem_req}), 128'(0));
      @(posedge clk); #1;
      dmem_ack = 1'b0; EX_MEM = '0;
      checkOutput("idle_ack mem_wb", 128'(MEM_WB), 128'({1'b1,1'b0,32'h0,32'h3C,5'd8}));
      checkOutput("idle_ack req", 128'(dmem_req), 128'(0));

      // Reset in the middle of WAIT drops the access and clears the sticky flags.
      EX_MEM = mk(1,1,1,0,32'h0,32'h80,5'd6);
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("midwait req", 128'(dmem_req), 128'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; EX_MEM = '0;
      checkOutput("midwait_rst req", 128'(dmem_req), 128'(0));
      checkOutput("midwait_rst mem_wb", 128'(MEM_WB), 128'(0));
      checkOutput("midwait_rst flags", 128'({misalign_err, timeout_err}), 128'(0));
      exp_mis = 1'b0; exp_to = 1'b0;
      rv = model_vec(mk(1,1,1,0,32'h0,32'h84,5'd10), 2, 32'h0BAD_CAFE, exp_mis, exp_to);
      applyStimulus(rv, "post_rst_load");

      for (int i = 0; i < 40; i++) begin
         logic [31:0] addr;
         logic [1:0]  kind;
         logic        rw, mtr, mr, mw;
         kind = 2'($urandom_range(0, 3));
         mr = (kind == 2'd1) || (kind == 2'd3);
         mw = (kind == 2'd2) || (kind == 2'd3 && $urandom_range(0, 1) == 1);
         rw = 1'($urandom); mtr = 1'($urandom);
         addr = $urandom;
         if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
         rv = model_vec(mk(rw, mtr, mr, mw, $urandom, addr, 5'($urandom)),
                        $urandom_range(0, TO + 1), $urandom, exp_mis, exp_to);
         exp_mis = rv.exp_mis; exp_to = rv.exp_to;
         applyStimulus(rv, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
